// File: rtl/c64_keymatrix.sv
// CIA1 keyboard/joystick matrix: event FIFO, typed-key sequencer and registered port resolution.
// Keys connect PA line a to PB line b; joysticks and RESTORE are merged in on the output side.
module c64_keymatrix #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] HOLD_TICKS = 16'd20000,
  parameter logic [15:0] GAP_TICKS  = 16'd20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi2_p,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_data,
  input  logic       clear_all,
  input  logic [7:0] pa_out,
  input  logic [7:0] pb_out,
  input  logic [4:0] joy_a,
  input  logic [4:0] joy_b,
  input  logic       restore_key,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       restore_n,
  output logic       busy
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  // A programmed tick count of 0 is treated as 1.
  localparam logic [15:0] HOLD_LOAD = (HOLD_TICKS == 16'd0) ? 16'd0 : HOLD_TICKS - 16'd1;
  localparam logic [15:0] GAP_LOAD  = (GAP_TICKS == 16'd0) ? 16'd0 : GAP_TICKS - 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0][7:0]  key_q, key_d;
  logic [5:0]       typed_q, typed_d;
  logic [7:0]       pa_in_q, pa_in_d, pb_in_q, pb_in_d;
  logic             restore_n_q;
  logic             push, pop;
  logic [7:0]       head;

  assign head     = fifo_q[rd_ptr_q];
  assign ev_ready = (count_q != DEPTH_C);
  assign push     = ev_valid && ev_ready && !clear_all;
  assign busy     = (state_q != S_IDLE) || (count_q != '0);
  assign pa_in    = pa_in_q;
  assign pb_in    = pb_in_q;
  assign restore_n = restore_n_q;

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= ev_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      typed_q     <= '0;
      pa_in_q     <= 8'hFF;
      pb_in_q     <= 8'hFF;
      restore_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      typed_q     <= typed_d;
      pa_in_q     <= pa_in_d;
      pb_in_q     <= pb_in_d;
      restore_n_q <= ~restore_key;
      if (clear_all) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_d;
      end
    end
  end

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if ((count_q != '0) && head[6]) state_d = S_HOLD;
      S_HOLD:  if (phi2_p && (cnt_q == 16'd0)) state_d = S_GAP;
      S_GAP:   if (phi2_p && (cnt_q == 16'd0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear_all) state_d = S_IDLE;
  end

  // Sequencer outputs: pop, matrix update and tick counter.
  always_comb begin
    pop     = 1'b0;
    key_d   = key_q;
    cnt_d   = cnt_q;
    typed_d = typed_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head[6]) begin
            key_d[head[5:3]][head[2:0]] = 1'b1;
            typed_d = head[5:0];
            cnt_d   = HOLD_LOAD;
          end else begin
            key_d[head[5:3]][head[2:0]] = head[7];
          end
        end
      end
      S_HOLD: begin
        if (phi2_p) begin
          if (cnt_q == 16'd0) begin
            key_d[typed_q[5:3]][typed_q[2:0]] = 1'b0;
            cnt_d = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      S_GAP: begin
        if (phi2_p && (cnt_q != 16'd0)) cnt_d = cnt_q - 16'd1;
      end
      default: ;
    endcase
    if (clear_all) begin
      pop   = 1'b0;
      key_d = '0;
      cnt_d = '0;
    end
  end

  // Single-level matrix resolution plus joystick overlay.
  always_comb begin
    pa_in_d = 8'hFF;
    pb_in_d = 8'hFF;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        if (key_q[a][b]) begin
          if (!pa_out[a]) pb_in_d[b] = 1'b0;
          if (!pb_out[b]) pa_in_d[a] = 1'b0;
        end
      end
    end
    pa_in_d[4:0] = pa_in_d[4:0] & ~joy_a;
    pb_in_d[4:0] = pb_in_d[4:0] & ~joy_b;
  end
endmodule

// File: tb/tb_c64_keymatrix.sv
// Directed bench for c64_keymatrix: matrix, joysticks, typed sequencer, FIFO full and clear_all.
module tb_c64_keymatrix;
  logic       clk = 1'b0;
  logic       reset, phi2_p, ev_valid, clear_all, restore_key;
  logic [7:0] ev_data, pa_out, pb_out;
  logic [4:0] joy_a, joy_b;
  logic       ev_ready, restore_n, busy;
  logic [7:0] pa_in, pb_in;
  int         errors = 0;
  int         checks = 0;

  c64_keymatrix #(.FIFO_DEPTH(4), .HOLD_TICKS(16'd3), .GAP_TICKS(16'd2)) dut (
    .clk(clk), .reset(reset), .phi2_p(phi2_p), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .clear_all(clear_all), .pa_out(pa_out), .pb_out(pb_out),
    .joy_a(joy_a), .joy_b(joy_b), .restore_key(restore_key), .pa_in(pa_in), .pb_in(pb_in),
    .restore_n(restore_n), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    phi2_p = 1'b1;
    tick(1);
    phi2_p = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] d);
    ev_valid = 1'b1;
    ev_data  = d;
    tick(1);
    ev_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; phi2_p = 1'b0; ev_valid = 1'b0; ev_data = 8'h00; clear_all = 1'b0;
    pa_out = 8'hFF; pb_out = 8'hFF; joy_a = '0; joy_b = '0; restore_key = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++; if (pa_in !== 8'hFF) begin errors++; $display("FAIL reset_pa_in: got %h want ff", pa_in); end
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL reset_pb_in: got %h want ff", pb_in); end
    checks++; if (restore_n !== 1'b1) begin errors++; $display("FAIL reset_restore_n: got %b want 1", restore_n); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ev_ready: got %b want 1", ev_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_matrix();
    pa_out = 8'hFD; pb_out = 8'hFF;
    push_one(8'h8D);
    tick(1);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL matrix_latency: got %h want ff", pb_in); end
    tick(1);
    checks++; if (pb_in !== 8'hDF) begin errors++; $display("FAIL matrix_pb_low: got %h want df", pb_in); end
    checks++; if (pa_in !== 8'hFF) begin errors++; $display("FAIL matrix_pa_idle: got %h want ff", pa_in); end
    pa_out = 8'hFF;
    tick(1);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL matrix_pb_high: got %h want ff", pb_in); end
    pb_out = 8'hDF;
    tick(1);
    checks++; if (pa_in !== 8'hFD) begin errors++; $display("FAIL matrix_pa_low: got %h want fd", pa_in); end
    push_one(8'h0D);
    tick(3);
    checks++; if (pa_in !== 8'hFF) begin errors++; $display("FAIL matrix_release: got %h want ff", pa_in); end
    pb_out = 8'hFF;
  endtask

  task automatic test_joystick();
    joy_b = 5'b10001;
    tick(1);
    checks++; if (pb_in !== 8'hEE) begin errors++; $display("FAIL joy_b: got %h want ee", pb_in); end
    joy_b = 5'b0; joy_a = 5'b00100;
    tick(1);
    checks++; if (pa_in !== 8'hFB) begin errors++; $display("FAIL joy_a: got %h want fb", pa_in); end
    joy_a = 5'b0; restore_key = 1'b1;
    tick(1);
    checks++; if (restore_n !== 1'b0) begin errors++; $display("FAIL restore_low: got %b want 0", restore_n); end
    restore_key = 1'b0;
    tick(1);
    checks++; if (restore_n !== 1'b1) begin errors++; $display("FAIL restore_high: got %b want 1", restore_n); end
  endtask

  task automatic test_typed();
    pa_out = 8'hF7;
    push_one(8'hDA);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL typed_busy_rise: got %b want 1", busy); end
    tick(2);
    checks++; if (pb_in !== 8'hFB) begin errors++; $display("FAIL typed_pressed: got %h want fb", pb_in); end
    push_one(8'h80);
    pa_out = 8'hF6;
    tick(5);
    checks++; if (pb_in !== 8'hFB) begin errors++; $display("FAIL typed_no_pop_hold: got %h want fb", pb_in); end
    strobe(); tick(7);
    strobe(); tick(7);
    checks++; if (pb_in !== 8'hFB) begin errors++; $display("FAIL typed_held_2: got %h want fb", pb_in); end
    strobe();
    tick(1);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL typed_released: got %h want ff", pb_in); end
    tick(6);
    strobe(); tick(7);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL typed_gap_no_pop: got %h want ff", pb_in); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL typed_gap_busy: got %b want 1", busy); end
    strobe();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL typed_idle_pending: got %b want 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL typed_busy_fall: got %b want 0", busy); end
    tick(1);
    checks++; if (pb_in !== 8'hFE) begin errors++; $display("FAIL typed_next_pop: got %h want fe", pb_in); end
    push_one(8'h00);
    tick(3);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL typed_cleanup: got %h want ff", pb_in); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] evs [5];
    evs[0] = 8'hDA; evs[1] = 8'h81; evs[2] = 8'h82; evs[3] = 8'h83; evs[4] = 8'h84;
    pa_out = 8'hFE;
    ev_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ev_data = evs[i];
      tick(1);
    end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: got %b want 0", ev_ready); end
    ev_data = 8'h85;
    tick(4);
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_hold: got %b want 0", ev_ready); end
    for (int s = 0; s < 4; s++) begin
      strobe(); tick(7);
    end
    strobe();
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_gap_end: got %b want 0", ev_ready); end
    tick(1);
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL fifo_ready_after_pop: got %b want 1", ev_ready); end
    tick(1);
    ev_valid = 1'b0;
    tick(6);
    checks++; if (pb_in !== 8'hC1) begin errors++; $display("FAIL fifo_all_popped: got %h want c1", pb_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fifo_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_clear_all();
    logic [7:0] evs [4];
    evs[0] = 8'hDA; evs[1] = 8'h86; evs[2] = 8'h87; evs[3] = 8'h88;
    pa_out = 8'h00; pb_out = 8'h00;
    ev_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev_data = evs[i];
      tick(1);
    end
    ev_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_pre_busy: got %b want 1", busy); end
    clear_all = 1'b1; ev_valid = 1'b1; ev_data = 8'h89;
    tick(1);
    clear_all = 1'b0; ev_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", ev_ready); end
    tick(1);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL clear_pb_in: got %h want ff", pb_in); end
    checks++; if (pa_in !== 8'hFF) begin errors++; $display("FAIL clear_pa_in: got %h want ff", pa_in); end
    tick(4);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL clear_push_dropped: got %h want ff", pb_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_stays_idle: got %b want 0", busy); end
    pa_out = 8'hFF; pb_out = 8'hFF;
  endtask

  task automatic test_reset_mid_hold();
    pa_out = 8'hF7;
    push_one(8'hDA);
    tick(2);
    checks++; if (pb_in !== 8'hFB) begin errors++; $display("FAIL rst_hold_pressed: got %h want fb", pb_in); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy: got %b want 0", busy); end
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL rst_hold_pb_in: got %h want ff", pb_in); end
    tick(2);
    checks++; if (pb_in !== 8'hFF) begin errors++; $display("FAIL rst_hold_released: got %h want ff", pb_in); end
    pa_out = 8'hFF;
  endtask

  initial begin
    test_reset();
    test_matrix();
    test_joystick();
    test_typed();
    test_fifo_full();
    test_clear_all();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
